// File: rtl/noc_output_port_arbiter_if.sv
// Handshake bundle between the router inputs and one output-port arbiter.
// master = router input side, slave = output-port arbiter.
interface noc_output_port_arbiter_if #(
   parameter int NUM_INPUTS   = 5,
   parameter int CREDIT_WIDTH = 3
);
   logic [NUM_INPUTS-1:0]   req;
   logic [NUM_INPUTS-1:0]   req_is_tail;
   logic [NUM_INPUTS-1:0]   turn_disable;
   logic                    credit_in;
   logic [NUM_INPUTS-1:0]   grant;
   logic                    send_out;
   logic [NUM_INPUTS-1:0]   pop;
   logic                    locked;
   logic [CREDIT_WIDTH-1:0] credit_count;
   logic                    credit_err;

   modport master (
      output req, req_is_tail, turn_disable, credit_in,
      input  grant, send_out, pop, locked, credit_count, credit_err
   );

   modport slave (
      input  req, req_is_tail, turn_disable, credit_in,
      output grant, send_out, pop, locked, credit_count, credit_err
   );
endinterface

// File: rtl/noc_output_port_arbiter.sv
// Round-robin, wormhole-locking, credit-tracking arbiter for one NoC router output port.
// Optional sticky credit-overflow detection: define NOC_ARB_CREDIT_CHECK_EN.
module noc_output_port_arbiter #(
   parameter int NUM_INPUTS        = 5,
   parameter int FLIT_BUFFER_DEPTH = 4,
   parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
   input  logic                       clk_noc,
   input  logic                       rst_n,
   noc_output_port_arbiter_if.slave   port_if
);

   localparam int PTR_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
   localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1'b1);
   localparam logic [PTR_W-1:0]        LAST_IDX   = PTR_W'(NUM_INPUTS - 1);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t                  state_q,  state_d;
   logic [PTR_W-1:0]        owner_q,  owner_d;
   logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CREDIT_WIDTH-1:0] credit_q, credit_d;

   logic [NUM_INPUTS-1:0]   eligible_s;
   logic                    pick_found_s;
   logic [PTR_W-1:0]        pick_idx_s;
   logic                    has_credit_s;
   logic [NUM_INPUTS-1:0]   grant_s;
   logic                    send_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == LAST_IDX) begin
         r = {PTR_W{1'b0}};
      end else begin
         r = p + PTR_W'(1'b1);
      end
      return r;
   endfunction

   function automatic logic [NUM_INPUTS-1:0] onehot(input logic [PTR_W-1:0] idx);
      logic [NUM_INPUTS-1:0] oh;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         oh[i] = (PTR_W'(i) == idx);
      end
      return oh;
   endfunction

   // First set bit of elig at or after start, wrapping; MSB of result is "found".
   function automatic logic [PTR_W:0] rr_pick(input logic [NUM_INPUTS-1:0] elig,
                                              input logic [PTR_W-1:0]      start);
      logic             found;
      logic [PTR_W-1:0] win;
      logic [PTR_W-1:0] idx;
      found = 1'b0;
      win   = {PTR_W{1'b0}};
      for (int k = 0; k < NUM_INPUTS; k++) begin
         idx = PTR_W'((int'(start) + k) % NUM_INPUTS);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end else begin
            found = found;
         end
      end
      return {found, win};
   endfunction

   // Arbitration, lock tracking and send decision.
   always_comb begin
      eligible_s                 = port_if.req & ~port_if.turn_disable;
      {pick_found_s, pick_idx_s} = rr_pick(eligible_s, rr_ptr_q);
      has_credit_s               = (credit_q != {CREDIT_WIDTH{1'b0}});
      state_d                    = state_q;
      owner_d                    = owner_q;
      rr_ptr_d                   = rr_ptr_q;
      grant_s                    = {NUM_INPUTS{1'b0}};
      send_s                     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_found_s && has_credit_s) begin
               grant_s = onehot(pick_idx_s);
               send_s  = 1'b1;
               if (port_if.req_is_tail[pick_idx_s]) begin
                  rr_ptr_d = ptr_inc(pick_idx_s);
               end else begin
                  state_d = ST_LOCKED;
                  owner_d = pick_idx_s;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            // Owner keeps the crossbar through bubbles; turn_disable no longer applies.
            grant_s = onehot(owner_q);
            if (port_if.req[owner_q] && has_credit_s) begin
               send_s = 1'b1;
               if (port_if.req_is_tail[owner_q]) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = ptr_inc(owner_q);
               end else begin
                  state_d = ST_LOCKED;
               end
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Downstream credit accounting, saturating at the buffer depth.
   always_comb begin
      credit_d = credit_q;
      case ({send_s, port_if.credit_in})
         2'b10: begin
            credit_d = credit_q - CREDIT_ONE;
         end
         2'b01: begin
            if (credit_q == CREDIT_MAX) begin
               credit_d = credit_q;
            end else begin
               credit_d = credit_q + CREDIT_ONE;
            end
         end
         default: begin
            credit_d = credit_q;
         end
      endcase
   end

   // State, owner, round-robin pointer and credit registers.
   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         owner_q  <= {PTR_W{1'b0}};
         rr_ptr_q <= {PTR_W{1'b0}};
         credit_q <= CREDIT_MAX;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         credit_q <= credit_d;
      end
   end

`ifdef NOC_ARB_CREDIT_CHECK_EN
   logic credit_err_q, credit_err_d;

   // A credit returned while already full means the downstream and we disagree.
   always_comb begin
      credit_err_d = credit_err_q |
                     (port_if.credit_in & (credit_q == CREDIT_MAX) & ~send_s);
   end

   // Sticky overflow flag, cleared only by reset.
   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         credit_err_q <= 1'b0;
      end else begin
         credit_err_q <= credit_err_d;
      end
   end

   assign port_if.credit_err = credit_err_q;
`else
   assign port_if.credit_err = 1'b0;
`endif

   assign port_if.grant        = grant_s;
   assign port_if.send_out     = send_s;
   assign port_if.pop          = grant_s & {NUM_INPUTS{send_s}};
   assign port_if.locked       = (state_q == ST_LOCKED);
   assign port_if.credit_count = credit_q;

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// Bench for noc_output_port_arbiter: directed vector table, async reset case and
// random traffic checked against a behavioural model of the arbitration rules.
module tb_noc_output_port_arbiter;

   localparam int N     = 5;
   localparam int DEPTH = 4;
   localparam int CW    = 3;
`ifdef NOC_ARB_CREDIT_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk_noc;
   logic rst_n;

   noc_output_port_arbiter_if #(.NUM_INPUTS(N), .CREDIT_WIDTH(CW)) bus ();

   noc_output_port_arbiter #(
      .NUM_INPUTS(N),
      .FLIT_BUFFER_DEPTH(DEPTH),
      .CREDIT_WIDTH(CW)
   ) dut (
      .clk_noc(clk_noc),
      .rst_n  (rst_n),
      .port_if(bus.slave)
   );

   initial clk_noc = 1'b0;
   always #5 clk_noc = ~clk_noc;

   int checks = 0;
   int errors = 0;

   // Reference model: owner = -1 when the port is free.
   int m_owner;
   int m_ptr;
   int m_credits;
   bit m_err;

   logic [N-1:0] s_grant;
   logic         s_send;
   logic         s_locked;
   logic [CW-1:0] s_credit;
   logic         s_err;

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] tail;
      logic [N-1:0] tdis;
      logic         cin;
      logic [N-1:0] exp_grant;
      logic         exp_send;
      logic         exp_locked;
      int           exp_credit;
      logic         exp_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [N-1:0] rq, input logic [N-1:0] tl,
                               input logic [N-1:0] td, input logic ci,
                               input logic [N-1:0] g, input logic s, input logic l,
                               input int c, input logic e);
      vec_t v;
      v.req = rq; v.tail = tl; v.tdis = td; v.cin = ci;
      v.exp_grant = g; v.exp_send = s; v.exp_locked = l; v.exp_credit = c; v.exp_err = e;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_owner   = -1;
      m_ptr     = 0;
      m_credits = DEPTH;
      m_err     = 1'b0;
   endfunction

   function automatic void model_eval(input logic [N-1:0] rq, input logic [N-1:0] td,
                                      output logic [N-1:0] g, output logic s, output int w);
      logic [N-1:0] elig;
      g = '0;
      s = 1'b0;
      w = -1;
      if (m_owner < 0) begin
         elig = rq & ~td;
         for (int k = 0; k < N; k++) begin
            if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         end
         if (w >= 0 && m_credits > 0) begin
            g = N'(1) << w;
            s = 1'b1;
         end
      end else begin
         w = m_owner;
         g = N'(1) << w;
         s = rq[w] && (m_credits > 0);
      end
   endfunction

   function automatic void model_update(input logic [N-1:0] rq, input logic [N-1:0] tl,
                                        input logic [N-1:0] td, input logic ci);
      logic [N-1:0] g;
      logic         s;
      int           w;
      model_eval(rq, td, g, s, w);
      if (s) begin
         if (tl[w]) begin
            m_owner = -1;
            m_ptr   = (w + 1) % N;
         end else begin
            m_owner = w;
         end
      end
      if (ERR_EN && ci && m_credits == DEPTH && !s) m_err = 1'b1;
      m_credits = m_credits + (ci ? 1 : 0) - (s ? 1 : 0);
      if (m_credits > DEPTH) m_credits = DEPTH;
   endfunction

   // Drive one cycle at the falling edge, sample just before the rising edge.
   task automatic run_cycle(input logic [N-1:0] rq, input logic [N-1:0] tl,
                            input logic [N-1:0] td, input logic ci);
      logic [N-1:0] eg;
      logic         es;
      int           ew;
      bus.req          = rq;
      bus.req_is_tail  = tl;
      bus.turn_disable = td;
      bus.credit_in    = ci;
      #4;
      model_eval(rq, td, eg, es, ew);
      s_grant  = bus.grant;
      s_send   = bus.send_out;
      s_locked = bus.locked;
      s_credit = bus.credit_count;
      s_err    = bus.credit_err;
      chk("model_grant",  int'(s_grant),  int'(eg));
      chk("model_send",   int'(s_send),   int'(es));
      chk("model_pop",    int'(bus.pop),  int'(es ? eg : '0));
      chk("model_locked", int'(s_locked), int'(m_owner >= 0));
      chk("model_credit", int'(s_credit), m_credits);
      chk("model_err",    int'(s_err),    int'(m_err));
      @(posedge clk_noc);
      model_update(rq, tl, td, ci);
      @(negedge clk_noc);
   endtask

   initial begin
      rst_n            = 1'b0;
      bus.req          = '0;
      bus.req_is_tail  = '0;
      bus.turn_disable = '0;
      bus.credit_in    = 1'b0;
      model_reset();

      // Single-flit local packets drain all credits.
      for (int c = 4; c >= 1; c--) vecs.push_back(mk(5'b00001, 5'b00001, 5'b0, 1'b0, 5'b00001, 1'b1, 1'b0, c, 1'b0));
      vecs.push_back(mk(5'b00001, 5'b00001, 5'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 0, 1'b0));
      for (int c = 0; c <= 3; c++) vecs.push_back(mk(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, 1'b0, 1'b0, c, 1'b0));
      // Round robin over inputs 1,2,4 with matched credit returns.
      for (int r = 0; r < 2; r++) begin
         vecs.push_back(mk(5'b10110, 5'b10110, 5'b0, 1'b1, 5'b00010, 1'b1, 1'b0, 4, 1'b0));
         vecs.push_back(mk(5'b10110, 5'b10110, 5'b0, 1'b1, 5'b00100, 1'b1, 1'b0, 4, 1'b0));
         vecs.push_back(mk(5'b10110, 5'b10110, 5'b0, 1'b1, 5'b10000, 1'b1, 1'b0, 4, 1'b0));
      end
      // Three-flit wormhole packet from input 2 holds off input 3.
      vecs.push_back(mk(5'b01100, 5'b01000, 5'b0, 1'b1, 5'b00100, 1'b1, 1'b0, 4, 1'b0));
      vecs.push_back(mk(5'b01100, 5'b01000, 5'b0, 1'b1, 5'b00100, 1'b1, 1'b1, 4, 1'b0));
      vecs.push_back(mk(5'b01100, 5'b01100, 5'b0, 1'b1, 5'b00100, 1'b1, 1'b1, 4, 1'b0));
      vecs.push_back(mk(5'b01000, 5'b01000, 5'b0, 1'b1, 5'b01000, 1'b1, 1'b0, 4, 1'b0));
      // Bubble while locked to input 1.
      vecs.push_back(mk(5'b00010, 5'b00000, 5'b0, 1'b1, 5'b00010, 1'b1, 1'b0, 4, 1'b0));
      vecs.push_back(mk(5'b00000, 5'b00000, 5'b0, 1'b0, 5'b00010, 1'b0, 1'b1, 4, 1'b0));
      vecs.push_back(mk(5'b00000, 5'b00000, 5'b0, 1'b0, 5'b00010, 1'b0, 1'b1, 4, 1'b0));
      vecs.push_back(mk(5'b00010, 5'b00010, 5'b0, 1'b1, 5'b00010, 1'b1, 1'b1, 4, 1'b0));
      vecs.push_back(mk(5'b00000, 5'b00000, 5'b0, 1'b0, 5'b00000, 1'b0, 1'b0, 4, 1'b0));
      // Disabled turn, then unmasked in the same cycle.
      vecs.push_back(mk(5'b01000, 5'b01000, 5'b01000, 1'b0, 5'b00000, 1'b0, 1'b0, 4, 1'b0));
      vecs.push_back(mk(5'b01000, 5'b01000, 5'b01000, 1'b0, 5'b00000, 1'b0, 1'b0, 4, 1'b0));
      vecs.push_back(mk(5'b01000, 5'b01000, 5'b00000, 1'b1, 5'b01000, 1'b1, 1'b0, 4, 1'b0));
      // Credit returned while already full.
      vecs.push_back(mk(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, 1'b0, 1'b0, 4, 1'b0));
      vecs.push_back(mk(5'b0, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0, 1'b0, 4, ERR_EN));

      repeat (2) @(negedge clk_noc);
      #4;
      chk("rst_grant",  int'(bus.grant),        0);
      chk("rst_send",   int'(bus.send_out),     0);
      chk("rst_pop",    int'(bus.pop),          0);
      chk("rst_locked", int'(bus.locked),       0);
      chk("rst_credit", int'(bus.credit_count), DEPTH);
      chk("rst_err",    int'(bus.credit_err),   0);
      @(negedge clk_noc);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         run_cycle(vecs[i].req, vecs[i].tail, vecs[i].tdis, vecs[i].cin);
         chk($sformatf("vec%0d_grant", i),  int'(s_grant),  int'(vecs[i].exp_grant));
         chk($sformatf("vec%0d_send", i),   int'(s_send),   int'(vecs[i].exp_send));
         chk($sformatf("vec%0d_locked", i), int'(s_locked), int'(vecs[i].exp_locked));
         chk($sformatf("vec%0d_credit", i), int'(s_credit), vecs[i].exp_credit);
         chk($sformatf("vec%0d_err", i),    int'(s_err),    int'(vecs[i].exp_err));
      end

      // Asynchronous reset in the middle of a packet from input 0.
      run_cycle(5'b00001, 5'b00000, 5'b0, 1'b0);
      #1;
      chk("pre_rst_locked", int'(bus.locked), 1);
      chk("pre_rst_credit", int'(bus.credit_count), DEPTH - 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_locked", int'(bus.locked),       0);
      chk("async_rst_credit", int'(bus.credit_count), DEPTH);
      chk("async_rst_err",    int'(bus.credit_err),   0);
      chk("async_rst_grant",  int'(bus.grant),        1);
      model_reset();
      @(negedge clk_noc);
      rst_n = 1'b1;

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         logic [N-1:0] rq, tl, td;
         logic         ci;
         rq = N'($urandom);
         tl = N'($urandom);
         td = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         ci = ($urandom_range(0, 2) == 0);
         run_cycle(rq, tl, td, ci);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/noc_output_port_arbiter.md
Name: noc_output_port_arbiter

Overview:
- Per-output-port controller for the 5-port NoC router. Shares one output port between all router inputs (local plus N/S/E/W) using round-robin arbitration.
- Wormhole switching: the output stays locked to the winning input until that input's tail flit has passed.
- Tracks downstream credits so a flit is sent only when the next-hop flit buffer has space. Drives send_out for the port and the crossbar select.

Parameters:
- NUM_INPUTS, 5, number of requesting router inputs (index 0 = local injection).
- FLIT_BUFFER_DEPTH, 4, downstream buffer depth; this is also the initial and maximum credit count.
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), width of the credit counter.

Ports:
- clk_noc  input  1  NoC clock; single clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  NUM_INPUTS  input i has a head-of-queue flit routed to this output.
- req_is_tail  input  NUM_INPUTS  the head flit of input i is a tail flit.
- turn_disable  input  NUM_INPUTS  masks input i from winning a new arbitration (disabled turn).
- credit_in  input  1  one credit returned by the downstream buffer.
- grant  output  NUM_INPUTS  one-hot crossbar select; all zeros when no owner.
- send_out  output  1  a flit moves through this output in this cycle.
- pop  output  NUM_INPUTS  one-hot dequeue to the winning input FIFO; equals grant & {NUM_INPUTS{send_out}}.
- locked  output  1  the port is held mid-packet.
- credit_count  output  CREDIT_WIDTH  credits currently available.
- credit_err  output  1  sticky credit overflow error (see Optional Feature).

Behaviour:
- Reset values: state IDLE, rr_ptr=0, owner=0, credit_count=FLIT_BUFFER_DEPTH. grant, send_out, pop, locked and credit_err are all 0.
- Reset asserted mid-packet drops the lock immediately and restores full credits. Packet recovery is outside this block.
- States: IDLE and LOCKED.
- IDLE, eligible set: eligible = req & ~turn_disable.
  - The winner is the first eligible index found searching from rr_ptr upward, wrapping past NUM_INPUTS-1 to 0.
  - If eligible != 0 and credit_count>0: grant is the one-hot winner and send_out=1, combinationally in the same cycle (zero-cycle arbitration latency).
- IDLE, transitions after a send:
  - If req_is_tail[winner]=1 (single-flit packet): stay IDLE and set rr_ptr = winner+1 mod NUM_INPUTS.
  - Otherwise: go to LOCKED and set owner=winner.
- IDLE, no send: if eligible != 0 but credit_count==0, then grant=0, send_out=0, and no state change.
- LOCKED:
  - grant is the one-hot owner. turn_disable is ignored.
  - send_out = req[owner] & (credit_count>0).
  - On a send with req_is_tail[owner]=1: go to IDLE and set rr_ptr = owner+1 mod NUM_INPUTS.
  - If req[owner]=0 (a bubble): hold the lock and send nothing.
- Credits:
  - send_out only: decrement. credit_in only: increment. Both in one cycle: unchanged.
  - The count never underflows, because send_out requires count>0.
  - If credit_in arrives at count==FLIT_BUFFER_DEPTH with no send, the count saturates at the depth.
- Registered outputs: state, owner, rr_ptr, credit_count and credit_err are registered. grant, send_out, pop and locked are combinational from the registered state and the current inputs.
- A new packet can be granted in the cycle immediately after a tail; there are no idle gap cycles.

Optional Feature:
- Macro: NOC_ARB_CREDIT_CHECK_EN.
- Defined: credit_err is set on any credit_in received while credit_count==FLIT_BUFFER_DEPTH and send_out=0. It stays set until rst_n is asserted.
- Undefined: credit_err is tied to 0 and no check logic is built. Counter saturation behaviour is identical in both cases.

Test Plan:
- Reset, then req=5'b00001 with tail=1 held for 4 cycles and no credit_in → 4 sends. credit_count goes 4→0 and the 5th cycle has send_out=0.
- Credits full; req=5'b10110 (all tail) held; turn_disable=0 → grants come in order 1,2,4,1,2,4, with credit_in pulsed each cycle to keep the count at 4.
- 3-flit packet from input 2 (tail on flit 3) while input 3 requests continuously → input 3 is not granted until the cycle after input 2's tail. locked=1 for exactly the cycles after flits 1 and 2.
- Locked to input 1 with req[1] dropped for 2 cycles → send_out=0, grant stays 5'b00010, and the packet completes when req[1] returns.
- turn_disable=5'b01000 with req=5'b01000 → no grant, state stays IDLE. Clear the mask → grant=5'b01000 in the same cycle.
- Macro defined: credit_in at count 4 with no send → credit_err=1 next cycle and the count stays 4. Assert rst_n low mid-packet → locked=0, count=4 and credit_err=0 asynchronously.
